// File: rtl/tl_pkg.sv
// tl_pkg: lane codes, phase words, phase index type and successor helper
// for the traffic-light signal monitor.
package tl_pkg;

  localparam logic [1:0] LANE_R = 2'b00;
  localparam logic [1:0] LANE_Y = 2'b01;
  localparam logic [1:0] LANE_G = 2'b10;

  localparam logic [7:0] PH_RST = 8'h55;
  localparam logic [7:0] PH_S0  = 8'h80;
  localparam logic [7:0] PH_S1  = 8'h50;
  localparam logic [7:0] PH_S2  = 8'h20;
  localparam logic [7:0] PH_S3  = 8'h14;
  localparam logic [7:0] PH_S4  = 8'h08;
  localparam logic [7:0] PH_S5  = 8'h05;
  localparam logic [7:0] PH_S6  = 8'h02;
  localparam logic [7:0] PH_S7  = 8'h41;

  typedef logic [2:0] phase_idx_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  function automatic phase_idx_t phase_succ(input phase_idx_t idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// tl_phase_decode: combinational classification of one signal-bus word.
module tl_phase_decode
  import tl_pkg::*;
(
  input  logic [7:0] sig_in,
  output logic       is_phase,
  output logic       is_rst,
  output phase_idx_t phase_idx,
  output logic       illegal,
  output logic       conflict
);

  logic [1:0] code;
  logic [2:0] n_green;

  // Phase lookup plus per-lane illegal/green counting.
  always_comb begin
    is_phase  = 1'b1;
    phase_idx = '0;
    case (sig_in)
      PH_S0:   phase_idx = 3'd0;
      PH_S1:   phase_idx = 3'd1;
      PH_S2:   phase_idx = 3'd2;
      PH_S3:   phase_idx = 3'd3;
      PH_S4:   phase_idx = 3'd4;
      PH_S5:   phase_idx = 3'd5;
      PH_S6:   phase_idx = 3'd6;
      PH_S7:   phase_idx = 3'd7;
      default: is_phase  = 1'b0;
    endcase
    is_rst  = (sig_in == PH_RST);
    illegal = 1'b0;
    n_green = '0;
    code    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      code = sig_in[2*i +: 2];
      if (code == 2'b11) illegal = 1'b1;
      n_green = n_green + 3'(code == LANE_G);
    end
    conflict = (n_green > 3'd1);
  end

endmodule

// File: rtl/tl_signal_monitor.sv
// tl_signal_monitor: lamp decode, phase-sequence lock tracking and sticky
// fault reporting for the 8-bit traffic-light signal bus.
// Optional watchdog: define TL_MON_WATCHDOG_EN.
module tl_signal_monitor
  import tl_pkg::*;
#(
  parameter int unsigned LOCK_LEN    = 2,
  parameter int unsigned WDOG_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sig_in,
  input  logic        sig_valid,
  input  logic        clr_err,
  output logic [3:0]  lamp_r,
  output logic [3:0]  lamp_y,
  output logic [3:0]  lamp_g,
  output logic        locked,
  output logic [2:0]  phase,
  output logic        err_illegal,
  output logic        err_conflict,
  output logic        err_sequence,
  output logic        err_timeout,
  output logic [7:0]  err_count,
  output logic [15:0] cycle_count
);

  logic       dec_is_phase, dec_is_rst, dec_illegal, dec_conflict;
  phase_idx_t dec_idx;

  tl_phase_decode u_decode (
    .sig_in    (sig_in),
    .is_phase  (dec_is_phase),
    .is_rst    (dec_is_rst),
    .phase_idx (dec_idx),
    .illegal   (dec_illegal),
    .conflict  (dec_conflict)
  );

  state_t     state_q, state_d;
  phase_idx_t exp_q, exp_d;
  logic       exp_vld_q, exp_vld_d;
  logic [2:0] prog_q, prog_d;
  logic [3:0] lamp_r_q, lamp_r_d, lamp_y_q, lamp_y_d, lamp_g_q, lamp_g_d;
  phase_idx_t phase_q, phase_d;
  logic       err_illegal_q, err_illegal_d;
  logic       err_conflict_q, err_conflict_d;
  logic       err_sequence_q, err_sequence_d;
  logic [7:0] err_count_q, err_count_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  logic       match, seq_err, fault, lamp_load, wdog_fire;
  logic [1:0] lane_code;

`ifdef TL_MON_WATCHDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic [7:0]  last_word_q, last_word_d;
  logic        blank_q, blank_d;
  logic        err_timeout_q, err_timeout_d;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

  assign match = dec_is_phase && exp_vld_q && (dec_idx == exp_q);

  // Next-state: lamp decode, lock FSM, watchdog and fault bookkeeping.
  always_comb begin
    state_d        = state_q;
    exp_d          = exp_q;
    exp_vld_d      = exp_vld_q;
    prog_d         = prog_q;
    lamp_r_d       = lamp_r_q;
    lamp_y_d       = lamp_y_q;
    lamp_g_d       = lamp_g_q;
    phase_d        = phase_q;
    err_illegal_d  = err_illegal_q;
    err_conflict_d = err_conflict_q;
    err_sequence_d = err_sequence_q;
    err_count_d    = err_count_q;
    cycle_count_d  = cycle_count_q;
    seq_err        = 1'b0;
    lamp_load      = 1'b1;
    wdog_fire      = 1'b0;
    lane_code      = '0;
`ifdef TL_MON_WATCHDOG_EN
    wdog_d         = wdog_q;
    last_word_d    = last_word_q;
    blank_d        = blank_q;
    err_timeout_d  = err_timeout_q;
`endif

    if (sig_valid) begin
`ifdef TL_MON_WATCHDOG_EN
      // after a timeout, lamps stay all-red until a phase word arrives
      if (blank_q && !(dec_is_phase || dec_is_rst)) lamp_load = 1'b0;
      else blank_d = 1'b0;
`endif
      if (lamp_load) begin
        for (int unsigned i = 0; i < 4; i++) begin
          lane_code   = sig_in[2*(3-i) +: 2];
          lamp_g_d[i] = (lane_code == LANE_G);
          lamp_y_d[i] = (lane_code == LANE_Y);
          lamp_r_d[i] = !((lane_code == LANE_G) || (lane_code == LANE_Y));
        end
      end
      if (dec_is_phase) phase_d = dec_idx;

      case (state_q)
        ST_LOCKED: begin
          if (match) begin
            exp_d = phase_succ(dec_idx);
            if (dec_idx == 3'd0) cycle_count_d = cycle_count_q + 16'd1;
          end else if (dec_is_rst) begin
            state_d   = ST_UNLOCKED;
            exp_d     = '0;
            exp_vld_d = 1'b1;
            prog_d    = '0;
          end else begin
            seq_err   = 1'b1;
            state_d   = ST_UNLOCKED;
            exp_d     = phase_succ(dec_idx);
            exp_vld_d = dec_is_phase;
            prog_d    = '0;
          end
        end
        default: begin
          if (dec_is_rst) begin
            exp_d     = '0;
            exp_vld_d = 1'b1;
            prog_d    = '0;
          end else if (match) begin
            exp_d = phase_succ(dec_idx);
            if (32'(prog_q) + 32'd1 >= LOCK_LEN) begin
              state_d = ST_LOCKED;
              prog_d  = '0;
            end else begin
              prog_d = prog_q + 3'd1;
            end
          end else begin
            exp_d     = phase_succ(dec_idx);
            exp_vld_d = dec_is_phase;
            prog_d    = '0;
          end
        end
      endcase
    end

`ifdef TL_MON_WATCHDOG_EN
    if (sig_valid) last_word_d = sig_in;
    if (state_q == ST_LOCKED && (!sig_valid || sig_in == last_word_q)) begin
      if (32'(wdog_q) + 32'd1 >= WDOG_CYCLES) begin
        wdog_fire = 1'b1;
        wdog_d    = '0;
      end else begin
        wdog_d = wdog_q + 16'd1;
      end
    end else begin
      wdog_d = '0;
    end
    if (wdog_fire) begin
      state_d   = ST_UNLOCKED;
      exp_vld_d = 1'b0;
      prog_d    = '0;
      lamp_r_d  = '1;
      lamp_y_d  = '0;
      lamp_g_d  = '0;
      blank_d   = 1'b1;
    end
`endif

    fault = (sig_valid && (dec_illegal || dec_conflict || seq_err)) || wdog_fire;

    if (sig_valid && clr_err) begin
      err_illegal_d  = dec_illegal;
      err_conflict_d = dec_conflict;
      err_sequence_d = seq_err;
      err_count_d    = fault ? 8'd1 : '0;
`ifdef TL_MON_WATCHDOG_EN
      err_timeout_d  = wdog_fire;
`endif
    end else begin
      err_illegal_d  = err_illegal_q  || (sig_valid && dec_illegal);
      err_conflict_d = err_conflict_q || (sig_valid && dec_conflict);
      err_sequence_d = err_sequence_q || seq_err;
      if (fault && err_count_q != '1) err_count_d = err_count_q + 8'd1;
`ifdef TL_MON_WATCHDOG_EN
      err_timeout_d  = err_timeout_q || wdog_fire;
`endif
    end
  end

  // State registers, asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_UNLOCKED;
      exp_q          <= '0;
      exp_vld_q      <= 1'b0;
      prog_q         <= '0;
      lamp_r_q       <= '1;
      lamp_y_q       <= '0;
      lamp_g_q       <= '0;
      phase_q        <= '0;
      err_illegal_q  <= 1'b0;
      err_conflict_q <= 1'b0;
      err_sequence_q <= 1'b0;
      err_count_q    <= '0;
      cycle_count_q  <= '0;
`ifdef TL_MON_WATCHDOG_EN
      wdog_q         <= '0;
      last_word_q    <= '0;
      blank_q        <= 1'b0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      exp_q          <= exp_d;
      exp_vld_q      <= exp_vld_d;
      prog_q         <= prog_d;
      lamp_r_q       <= lamp_r_d;
      lamp_y_q       <= lamp_y_d;
      lamp_g_q       <= lamp_g_d;
      phase_q        <= phase_d;
      err_illegal_q  <= err_illegal_d;
      err_conflict_q <= err_conflict_d;
      err_sequence_q <= err_sequence_d;
      err_count_q    <= err_count_d;
      cycle_count_q  <= cycle_count_d;
`ifdef TL_MON_WATCHDOG_EN
      wdog_q         <= wdog_d;
      last_word_q    <= last_word_d;
      blank_q        <= blank_d;
      err_timeout_q  <= err_timeout_d;
`endif
    end
  end

  assign lamp_r       = lamp_r_q;
  assign lamp_y       = lamp_y_q;
  assign lamp_g       = lamp_g_q;
  assign locked       = (state_q == ST_LOCKED);
  assign phase        = phase_q;
  assign err_illegal  = err_illegal_q;
  assign err_conflict = err_conflict_q;
  assign err_sequence = err_sequence_q;
  assign err_count    = err_count_q;
  assign cycle_count  = cycle_count_q;
`ifdef TL_MON_WATCHDOG_EN
  assign err_timeout  = err_timeout_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_tl_signal_monitor.sv
// tb_tl_signal_monitor: scoreboard bench for tl_signal_monitor with a
// behavioural reference model; TL_MON_WATCHDOG_EN adds the timeout scenario.
module tb_tl_signal_monitor;

  localparam int LOCK_LEN = 2;
  localparam int WDOG     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sig_in = '0;
  logic        sig_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic [3:0]  lamp_r, lamp_y, lamp_g;
  logic        locked;
  logic [2:0]  phase;
  logic        err_illegal, err_conflict, err_sequence, err_timeout;
  logic [7:0]  err_count;
  logic [15:0] cycle_count;

  tl_signal_monitor #(.LOCK_LEN(LOCK_LEN), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .sig_valid(sig_valid), .clr_err(clr_err),
    .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g), .locked(locked), .phase(phase),
    .err_illegal(err_illegal), .err_conflict(err_conflict), .err_sequence(err_sequence),
    .err_timeout(err_timeout), .err_count(err_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  logic [43:0] dut_vec;
  assign dut_vec = {lamp_r, lamp_y, lamp_g, locked, phase, err_illegal, err_conflict,
                    err_sequence, err_timeout, err_count, cycle_count};

  logic [7:0] ph_tab [8] = '{8'h80, 8'h50, 8'h20, 8'h14, 8'h08, 8'h05, 8'h02, 8'h41};

  // reference model state: expected index -1 means "no expectation"
  int   m_exp, m_prog, m_ph, m_cnt, m_cyc, m_idle;
  bit   m_lk, m_ill, m_conf, m_seq, m_tmo, m_blank;
  logic [3:0] m_r, m_y, m_g;

  logic [43:0] sb [$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void m_reset();
    m_exp = -1; m_prog = 0; m_ph = 0; m_cnt = 0; m_cyc = 0; m_idle = 0;
    m_lk = 0; m_ill = 0; m_conf = 0; m_seq = 0; m_tmo = 0; m_blank = 0;
    m_r = 4'hF; m_y = 4'h0; m_g = 4'h0;
  endfunction

  function automatic int find_phase(input logic [7:0] w);
    for (int i = 0; i < 8; i++) if (ph_tab[i] == w) return i;
    return -1;
  endfunction

  function automatic void m_step(input logic [7:0] w, input bit v, input bit c);
    int idx, code, greens;
    bit rstw, ill, conf, seq, faulty;
    if (!v) begin
`ifdef TL_MON_WATCHDOG_EN
      if (m_lk) begin
        m_idle++;
        if (m_idle == WDOG) begin
          m_lk = 0; m_exp = -1; m_prog = 0; m_idle = 0;
          m_r = 4'hF; m_y = 0; m_g = 0; m_blank = 1; m_tmo = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end else m_idle = 0;
`endif
      return;
    end
    m_idle = 0;
    idx = find_phase(w);
    rstw = (w == 8'h55);
    ill = 0; greens = 0;
    for (int l = 0; l < 4; l++) begin
      code = (int'(w) >> (6 - 2*l)) & 3;
      if (code == 3) ill = 1;
      if (code == 2) greens++;
    end
    conf = (greens > 1);
    if (!(m_blank && idx < 0 && !rstw)) begin
      m_blank = 0;
      for (int l = 0; l < 4; l++) begin
        code = (int'(w) >> (6 - 2*l)) & 3;
        m_g[l] = (code == 2);
        m_y[l] = (code == 1);
        m_r[l] = (code == 0 || code == 3);
      end
    end
    if (idx >= 0) m_ph = idx;
    seq = 0;
    if (m_lk) begin
      if (idx >= 0 && idx == m_exp) begin
        if (idx == 0) m_cyc = (m_cyc + 1) % 65536;
        m_exp = (idx + 1) % 8;
      end else if (rstw) begin
        m_lk = 0; m_exp = 0; m_prog = 0;
      end else begin
        seq = 1; m_lk = 0; m_prog = 0;
        m_exp = (idx >= 0) ? (idx + 1) % 8 : -1;
      end
    end else begin
      if (rstw) begin
        m_exp = 0; m_prog = 0;
      end else if (idx >= 0 && idx == m_exp) begin
        m_prog++;
        m_exp = (idx + 1) % 8;
        if (m_prog == LOCK_LEN) begin m_lk = 1; m_prog = 0; end
      end else begin
        m_prog = 0;
        m_exp = (idx >= 0) ? (idx + 1) % 8 : -1;
      end
    end
    faulty = ill || conf || seq;
    if (c) begin
      m_ill = ill; m_conf = conf; m_seq = seq; m_tmo = 0;
      m_cnt = faulty ? 1 : 0;
    end else begin
      m_ill |= ill; m_conf |= conf; m_seq |= seq;
      if (faulty && m_cnt < 255) m_cnt++;
    end
  endfunction

  function automatic logic [43:0] m_vec();
    return {m_r, m_y, m_g, m_lk, 3'(m_ph), m_ill, m_conf, m_seq, m_tmo, 8'(m_cnt), 16'(m_cyc)};
  endfunction

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] w, input bit v, input bit c);
    @(negedge clk);
    sig_in = w; sig_valid = v; clr_err = c;
    m_step(w, v, c);
    sb.push_back(m_vec());
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && sb.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    n_tests++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    sig_valid = 0; clr_err = 0;
    rst = 1;
    #1;
    m_reset();
    check("reset", dut_vec, m_vec());
    @(negedge clk);
    rst = 0;
  endtask

  // scoreboard monitor: one expected entry per sampled clock edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) check("sample", dut_vec, sb.pop_front());
    end
  end

  initial begin
    int gp, r, ix;
    bit c;
    #2;
    do_reset();

    // lock: RST, S0, S1
    drive(8'h55, 1, 0); drive(8'h80, 1, 0); drive(8'h50, 1, 0);
    drain();
    check("plan_lock", {28'd0, locked, phase, lamp_y, lamp_r}, {28'd0, 1'b1, 3'd1, 4'b0011, 4'b1100});

    // finish the current loop, then three full loops
    for (int i = 2; i < 8; i++) drive(ph_tab[i], 1, 0);
    for (int n = 0; n < 3; n++) for (int i = 0; i < 8; i++) drive(ph_tab[i], 1, 0);
    drain();
    check("plan_loops", {16'd0, err_illegal, err_conflict, err_sequence, err_timeout, err_count, cycle_count},
          {16'd0, 4'b0000, 8'd0, 16'd3});

    // out-of-order S2 while expecting S1, then relock via S3, S4
    drive(8'h80, 1, 0); drive(8'h20, 1, 0);
    drain();
    check("plan_seq", {34'd0, err_sequence, locked, err_count}, {34'd0, 1'b1, 1'b0, 8'd1});
    drive(8'h14, 1, 0); drive(8'h08, 1, 0);
    drain();
    check("plan_relock", {43'd0, locked}, {43'd0, 1'b1});

    // conflict, then illegal with clear
    drive(8'hA0, 1, 0);
    drain();
    check("plan_conflict", {39'd0, err_conflict, lamp_g}, {39'd0, 1'b1, 4'b0011});
    drive(8'hC0, 1, 1);
    drain();
    check("plan_clr", {30'd0, err_illegal, err_conflict, err_count, lamp_r}, {30'd0, 1'b1, 1'b0, 8'd1, 4'hF});

    // saturation, then asynchronous reset mid-run
    for (int i = 0; i < 300; i++) drive(8'hC0, 1, 0);
    drain();
    check("plan_sat", {36'd0, err_count}, {36'd0, 8'd255});
    drive(8'hC0, 1, 0); drive(8'h55, 1, 0);
    drain();
    do_reset();

    // randomized traffic
    gp = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 19) == 0);
      if (r < 60) begin
        drive(ph_tab[gp], 1, c); gp = (gp + 1) % 8;
      end else if (r < 65) begin
        drive(8'h55, 1, c); gp = 0;
      end else if (r < 78) begin
        ix = $urandom_range(0, 7);
        drive(ph_tab[ix], 1, c); gp = (ix + 1) % 8;
      end else if (r < 90) begin
        drive(8'($urandom), 1, c);
      end else begin
`ifdef TL_MON_WATCHDOG_EN
        drive(8'($urandom), 1, c);
`else
        drive(8'($urandom), 0, 0);
`endif
      end
    end
    drain();

`ifdef TL_MON_WATCHDOG_EN
    do_reset();
    drive(8'h55, 1, 0); drive(8'h80, 1, 0); drive(8'h50, 1, 0);
    for (int i = 0; i < WDOG; i++) drive(8'h00, 0, 0);
    drain();
    check("plan_wdog", {38'd0, err_timeout, locked, lamp_r}, {38'd0, 1'b1, 1'b0, 4'hF});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
